// File: rtl/typec_bag_seq.sv
// Packet-sequence engine for the Type-C link: walks a programmable list of bag
// types through a transmitter, waits for each packet to return through the
// receiver, and keeps packet/pass/error statistics.
module typec_bag_seq #(
  parameter int unsigned SEQ_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned BTW     = 4,
  parameter int unsigned TO_W    = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [SEQ_LEN*BTW-1:0] seq_list_i,
  input  logic [LEN_W-1:0]       seq_num_i,
  input  logic [CNT_W-1:0]       loops_i,
  input  logic [TO_W-1:0]        timeout_i,
  output logic [BTW-1:0]         btype_o,
  output logic                   tx_fs_o,
  input  logic                   tx_fd_i,
  input  logic                   rx_fs_i,
  output logic                   rx_fd_o,
  input  logic [BTW-1:0]         rx_btype_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_W-1:0]       pkt_cnt_o,
  output logic [CNT_W-1:0]       pass_cnt_o,
  output logic [CNT_W-1:0]       err_cnt_o,
  output logic                   to_flag_o
);

  localparam logic [LEN_W-1:0] SeqLenW = LEN_W'(SEQ_LEN);

  typedef enum logic [2:0] {StIdle, StPrep, StTx, StWrx, StRrx, StNext, StDone} state_e;

  state_e                 state_q, state_d;
  logic [SEQ_LEN*BTW-1:0] list_q, list_d;
  logic [LEN_W-1:0]       num_q, num_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       loops_q, loops_d;
  logic [TO_W-1:0]        timeout_q, timeout_d;
  logic [TO_W-1:0]        timer_q, timer_d;
  logic [BTW-1:0]         btype_q, btype_d;
  logic [CNT_W-1:0]       pkt_q, pkt_d;
  logic [CNT_W-1:0]       pass_q, pass_d;
  logic [CNT_W-1:0]       err_q, err_d;
  logic                   to_q, to_d;
  logic                   stop_q, stop_d;
  logic                   first_q, first_d;

  logic [BTW-1:0]   entry;
  logic             last;
  logic [CNT_W-1:0] pass_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      list_q    <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      loops_q   <= '0;
      timeout_q <= '0;
      timer_q   <= '0;
      btype_q   <= '0;
      pkt_q     <= '0;
      pass_q    <= '0;
      err_q     <= '0;
      to_q      <= 1'b0;
      stop_q    <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      list_q    <= list_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      loops_q   <= loops_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
      btype_q   <= btype_d;
      pkt_q     <= pkt_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      to_q      <= to_d;
      stop_q    <= stop_d;
      first_q   <= first_d;
    end
  end

  // Next-state logic: sequencing, timeout, btype check and statistics.
  always_comb begin
    state_d   = state_q;
    list_d    = list_q;
    num_d     = num_q;
    idx_d     = idx_q;
    loops_d   = loops_q;
    timeout_d = timeout_q;
    timer_d   = timer_q;
    btype_d   = btype_q;
    pkt_d     = pkt_q;
    pass_d    = pass_q;
    err_d     = err_q;
    to_d      = to_q;
    stop_d    = stop_q;
    first_d   = first_q;

    entry = '0;
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      if (idx_q == LEN_W'(i)) entry = list_q[i*BTW +: BTW];
    end
    last     = (idx_q == num_q - 1'b1);
    pass_inc = sat_inc(pass_q);

    if (stop_i && (state_q != StIdle)) stop_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          list_d    = seq_list_i;
          // Out-of-range lengths fall back to the full list.
          num_d     = ((seq_num_i == '0) || (seq_num_i > SeqLenW)) ? SeqLenW : seq_num_i;
          loops_d   = loops_i;
          timeout_d = timeout_i;
          pkt_d     = '0;
          pass_d    = '0;
          err_d     = '0;
          to_d      = 1'b0;
          stop_d    = 1'b0;
          idx_d     = '0;
          state_d   = StPrep;
        end
      end
      StPrep: begin
        btype_d = entry;
        state_d = StTx;
      end
      StTx: begin
        if (tx_fd_i) begin
          timer_d = '0;
          state_d = StWrx;
        end
      end
      StWrx: begin
        if (rx_fs_i) begin
          first_d = 1'b1;
          state_d = StRrx;
        end else begin
          if (timer_q != '1) timer_d = timer_q + 1'b1;
          if ((timeout_q != '0) && (timer_q == timeout_q - 1'b1)) begin
            err_d   = sat_inc(err_q);
            to_d    = 1'b1;
            state_d = StNext;
          end
        end
      end
      StRrx: begin
        first_d = 1'b0;
        // Only the first cycle is compared so a packet counts at most once.
        if (first_q && (rx_btype_i != btype_q)) err_d = sat_inc(err_q);
        if (!rx_fs_i) state_d = StNext;
      end
      StNext: begin
        pkt_d = sat_inc(pkt_q);
        if (last) begin
          idx_d  = '0;
          pass_d = pass_inc;
          if ((loops_q != '0) && (pass_inc == loops_q)) state_d = StDone;
          else if (stop_q)                              state_d = StDone;
          else                                          state_d = StPrep;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = stop_q ? StDone : StPrep;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs; TX and RRX are distinct states so tx_fs and rx_fd never overlap.
  always_comb begin
    btype_o    = btype_q;
    tx_fs_o    = (state_q == StTx);
    rx_fd_o    = (state_q == StRrx);
    busy_o     = (state_q != StIdle);
    done_o     = (state_q == StDone);
    pkt_cnt_o  = pkt_q;
    pass_cnt_o = pass_q;
    err_cnt_o  = err_q;
    to_flag_o  = to_q;
  end

endmodule

// File: tb/tb_typec_bag_seq.sv
// Bench for typec_bag_seq: a loopback transmitter/receiver responder plus a
// list-based reference model of the expected packet order and statistics.
module tb_typec_bag_seq;

  localparam int SEQ_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int BTW     = 4;
  localparam int TO_W    = 16;
  localparam int CNT_W   = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start, stop;
  logic [SEQ_LEN*BTW-1:0] seq_list;
  logic [LEN_W-1:0]       seq_num;
  logic [CNT_W-1:0]       loops;
  logic [TO_W-1:0]        timeout;
  logic [BTW-1:0]         btype;
  logic                   tx_fs, tx_fd, rx_fs, rx_fd;
  logic [BTW-1:0]         rx_btype;
  logic                   busy, done, to_flag;
  logic [CNT_W-1:0]       pkt_cnt, pass_cnt, err_cnt;

  typec_bag_seq #(
    .SEQ_LEN(SEQ_LEN), .LEN_W(LEN_W), .BTW(BTW), .TO_W(TO_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst(rst), .start_i(start), .stop_i(stop),
    .seq_list_i(seq_list), .seq_num_i(seq_num), .loops_i(loops), .timeout_i(timeout),
    .btype_o(btype), .tx_fs_o(tx_fs), .tx_fd_i(tx_fd), .rx_fs_i(rx_fs), .rx_fd_o(rx_fd),
    .rx_btype_i(rx_btype), .busy_o(busy), .done_o(done), .pkt_cnt_o(pkt_cnt),
    .pass_cnt_o(pass_cnt), .err_cnt_o(err_cnt), .to_flag_o(to_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Responder configuration and observations.
  int       tx_dly, rx_dly, rx_hold;
  bit       corrupt_mask[512];
  bit       drop_mask[512];
  logic [BTW-1:0] obs_q[$];
  int       cyc = 0;
  int       drop_cyc = 0;
  bit       drop_pending = 0;
  int       gap = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loopback responder: acks tx_fs after tx_dly, returns the packet after rx_dly.
  initial begin
    int phase, dly, hold, cur_pkt;
    logic [BTW-1:0] cur_bt;
    phase = 0; dly = 0; hold = 0; cur_pkt = 0; cur_bt = '0;
    tx_fd = 1'b0; rx_fs = 1'b0; rx_btype = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        phase = 0; tx_fd = 1'b0; rx_fs = 1'b0;
      end else begin
        check("tx_rx_excl", {31'b0, tx_fs & rx_fd}, 32'd0);
        case (phase)
          0: if (tx_fs) begin
            cur_bt  = btype;
            cur_pkt = obs_q.size();
            obs_q.push_back(btype);
            if (drop_pending) begin
              gap = cyc - drop_cyc;
              drop_pending = 0;
            end
            dly = tx_dly; phase = 1;
          end
          1: if (dly == 0) begin tx_fd = 1'b1; phase = 2; end else dly--;
          2: if (!tx_fs) begin
            tx_fd = 1'b0;
            if (drop_mask[cur_pkt]) begin
              drop_cyc = cyc; drop_pending = 1; phase = 0;
            end else begin
              dly = rx_dly; phase = 3;
            end
          end
          3: if (dly == 0) begin
            rx_btype = corrupt_mask[cur_pkt] ? (cur_bt ^ 4'h1) : cur_bt;
            rx_fs = 1'b1; hold = rx_hold; phase = 4;
          end else dly--;
          4: if (rx_fd) begin
            if (hold == 0) begin rx_fs = 1'b0; phase = 0; end else hold--;
          end
          default: phase = 0;
        endcase
      end
    end
  end

  function automatic int eff_num(input int n);
    return (n == 0 || n > SEQ_LEN) ? SEQ_LEN : n;
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < 512; i++) begin corrupt_mask[i] = 0; drop_mask[i] = 0; end
    obs_q.delete();
    gap = -1;
    drop_pending = 0;
  endtask

  task automatic start_run(input logic [31:0] l, input int n, input int lp, input int to);
    seq_list = l; seq_num = LEN_W'(n); loops = CNT_W'(lp); timeout = TO_W'(to);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int e_pkt, input int e_pass,
                            input int e_err, input int e_to);
    bit seen;
    seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check({tag, "_done"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      check({tag, "_pkt"}, {16'b0, pkt_cnt}, e_pkt);
      check({tag, "_pass"}, {16'b0, pass_cnt}, e_pass);
      check({tag, "_err"}, {16'b0, err_cnt}, e_err);
      check({tag, "_to"}, {31'b0, to_flag}, e_to);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
      check({tag, "_idle"}, {31'b0, busy}, 32'd0);
      check({tag, "_pkt_hold"}, {16'b0, pkt_cnt}, e_pkt);
    end
  endtask

  task automatic check_seq(input string tag, input logic [31:0] l, input int en, input int npk);
    logic [BTW-1:0] e;
    check({tag, "_nobs"}, obs_q.size(), npk);
    for (int k = 0; k < npk && k < obs_q.size(); k++) begin
      e = l[(k % en)*BTW +: BTW];
      check($sformatf("%s_bt%0d", tag, k), {28'b0, obs_q[k]}, {28'b0, e});
    end
  endtask

  initial begin
    logic [31:0] lst;
    int n, en, lp, to, npk, e_err, e_to;
    bit ok;

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    seq_list = '0; seq_num = '0; loops = '0; timeout = '0;
    tx_dly = 1; rx_dly = 1; rx_hold = 0;
    clear_cfg();
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_txfs", {31'b0, tx_fs}, 0);
    check("rst_rxfd", {31'b0, rx_fd}, 0);
    check("rst_btype", {28'b0, btype}, 0);
    check("rst_cnts", {pkt_cnt, pass_cnt}, 0);
    check("rst_err", {16'b0, err_cnt}, 0);
    check("rst_to", {31'b0, to_flag}, 0);
    rst = 1'b0;
    @(negedge clk);
    // stop while idle must not leak into the next run
    stop = 1'b1; @(negedge clk); stop = 1'b0;

    // Fixed ACK..DATA0 list, two passes, ideal loopback.
    lst = {4'h0, 4'hD, 4'hA, 4'h9, 4'h8, 4'h3, 4'h2, 4'h1};
    clear_cfg();
    start_run(lst, 7, 2, 0);
    finish_run("basic", 14, 2, 0, 0);
    check_seq("basic", lst, 7, 14);

    // One corrupted return on entry 1 (2 comes back as 3).
    clear_cfg(); corrupt_mask[1] = 1;
    start_run(lst, 7, 1, 0);
    finish_run("mism", 7, 1, 1, 0);
    check_seq("mism", lst, 7, 7);

    // Missing response for entry 0 with timeout=100.
    clear_cfg(); drop_mask[0] = 1;
    start_run(lst, 7, 1, 100);
    finish_run("tmo", 7, 1, 1, 1);
    check_seq("tmo", lst, 7, 7);
    // 100 WRX cycles, then NEXT and PREP before the next tx_fs
    check("tmo_gap", gap, 102);

    // Free-running; stop during TX of entry 4 on the second pass.
    lst = $urandom;
    clear_cfg(); tx_dly = 4;
    start_run(lst, 7, 0, 0);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (obs_q.size() == 12) begin ok = 1; break; end
    end
    check("stop_reach", {31'b0, ok}, 1);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    finish_run("stop", 12, 1, 0, 0);
    check_seq("stop", lst, 7, 12);
    tx_dly = 1;

    // seq_num=0 means full list; a second start while busy is ignored.
    lst = 32'h7654_3210 ^ $urandom;
    clear_cfg();
    start_run(lst, 0, 1, 0);
    repeat (5) @(negedge clk);
    seq_list = ~lst; seq_num = 4'd3; loops = 16'd5;
    start = 1'b1; @(negedge clk); start = 1'b0;
    finish_run("full", 8, 1, 0, 0);
    check_seq("full", lst, 8, 8);

    // Reset while the receiver is being acknowledged.
    clear_cfg(); rx_hold = 3;
    start_run(lst, 5, 1, 0);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (obs_q.size() >= 3 && rx_fd) begin ok = 1; break; end
    end
    check("rrx_reach", {31'b0, ok}, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {30'b0, busy, done}, 0);
    check("mid_rst_hs", {30'b0, tx_fs, rx_fd}, 0);
    check("mid_rst_btype", {28'b0, btype}, 0);
    check("mid_rst_cnts", {pkt_cnt, pass_cnt}, 0);
    check("mid_rst_err", {15'b0, err_cnt, to_flag}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_cfg(); rx_hold = 0;
    start_run(lst, 3, 1, 0);
    finish_run("post_rst", 3, 1, 0, 0);
    check_seq("post_rst", lst, 3, 3);

    // Randomised runs checked against the list model.
    for (int r = 0; r < 8; r++) begin
      clear_cfg();
      lst = $urandom;
      n = $urandom_range(0, 15);
      lp = $urandom_range(1, 3);
      tx_dly = $urandom_range(0, 3);
      rx_dly = $urandom_range(0, 4);
      rx_hold = $urandom_range(0, 3);
      to = ($urandom_range(0, 1) == 1) ? $urandom_range(30, 60) : 0;
      en = eff_num(n);
      npk = en * lp;
      e_err = 0; e_to = 0;
      for (int k = 0; k < npk; k++) begin
        if (to != 0 && $urandom_range(0, 5) == 0) begin
          drop_mask[k] = 1; e_err++; e_to = 1;
        end else if ($urandom_range(0, 4) == 0) begin
          corrupt_mask[k] = 1; e_err++;
        end
      end
      start_run(lst, n, lp, to);
      finish_run($sformatf("rnd%0d", r), npk, lp, e_err, e_to);
      check_seq($sformatf("rnd%0d", r), lst, en, npk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
